std_seq_divmod: RTL and testbench



---
 rtl/std_seq_divmod_pkg.sv | 18 +
 rtl/std_seq_divmod_step.sv | 32 +++
 rtl/std_seq_divmod.sv | 163 ++++++++++++++++
 tb/tb_std_seq_divmod.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/std_seq_divmod_pkg.sv
// std_seq_divmod_pkg
// Shared definitions for the sequential divider slice: the controller
// state encoding and a helper that sizes the iteration counter.
// Optional feature macro used by this slice: STD_SEQ_DIVMOD_SIGNED_EN.
package std_seq_divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter is loaded with WIDTH itself, so it needs room for WIDTH+1 values.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/std_seq_divmod_step.sv
// std_seq_divmod_step
// One purely combinational restoring-division iteration.
// Ports:
//   rem_i          partial remainder (WIDTH+1 bits)
//   dividendBit_i  next dividend bit, MSB first
//   divisor_i      divisor magnitude
//   rem_o          next partial remainder
//   quoBit_o       quotient bit produced by this iteration
module std_seq_divmod_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dividendBit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             quoBit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtract one bit wider than the shifted remainder so the borrow
  // shows up as the sign bit. A set top bit in rem_i means the shifted value
  // already exceeds any divisor, so the subtract must succeed.
  always_comb begin
    shifted  = {rem_i[WIDTH-1:0], dividendBit_i};
    diff     = {1'b0, shifted} - {2'b00, divisor_i};
    quoBit_o = rem_i[WIDTH] | ~diff[WIDTH+1];
    rem_o    = quoBit_o ? diff[WIDTH:0] : shifted;
  end

endmodule

// File: rtl/std_seq_divmod.sv
// std_seq_divmod
// Multi-cycle divider producing quotient and remainder with a go/done
// handshake. One quotient bit is resolved per cycle, MSB first; a result
// is presented WIDTH+1 cycles after go is accepted.
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   go             start request, sampled only when not busy
//   left, right    dividend and divisor, sampled with go
//   out_quotient   quotient, held until the next accepted go completes
//   out_remainder  remainder, held likewise
//   done           single-cycle pulse, results valid in that cycle
// Optional macro STD_SEQ_DIVMOD_SIGNED_EN selects two's complement
// operation (truncating quotient, remainder takes the dividend's sign).
module std_seq_divmod
  import std_seq_divmod_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH:0]   partRem_q, partRem_d;
  logic [WIDTH-1:0] resQuo_q, resQuo_d;
  logic [WIDTH-1:0] resRem_q, resRem_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   stepRem;
  logic             stepQuoBit;
  logic             accept;
  logic [WIDTH-1:0] leftMag, rightMag;
  logic [WIDTH-1:0] quoFinal, remFinal, quoFixed, remFixed;

  // dq_q starts as the dividend; each iteration shifts its MSB into the
  // remainder and the new quotient bit into its LSB, so after WIDTH steps it
  // holds the quotient.
  std_seq_divmod_step #(.WIDTH(WIDTH)) uStep (
    .rem_i         (partRem_q),
    .dividendBit_i (dq_q[WIDTH-1]),
    .divisor_i     (divisor_q),
    .rem_o         (stepRem),
    .quoBit_o      (stepQuoBit)
  );

  assign accept   = go && (state_q != BUSY);
  assign quoFinal = {dq_q[WIDTH-2:0], stepQuoBit};
  assign remFinal = stepRem[WIDTH-1:0];

`ifdef STD_SEQ_DIVMOD_SIGNED_EN
  logic negQuo_q, negQuo_d, negRem_q, negRem_d;

  // Iterate on magnitudes. The most-negative value negates to itself, which
  // read as unsigned is exactly its magnitude.
  assign leftMag  = left[WIDTH-1]  ? -left  : left;
  assign rightMag = right[WIDTH-1] ? -right : right;
  assign quoFixed = negQuo_q ? -quoFinal : quoFinal;
  assign remFixed = negRem_q ? -remFinal : remFinal;

  // Sign flags are captured with the operands. A zero divisor leaves the
  // all-ones quotient untouched, and negating |left| restores left exactly.
  always_comb begin
    negQuo_d = negQuo_q;
    negRem_d = negRem_q;
    if (accept) begin
      negQuo_d = (left[WIDTH-1] ^ right[WIDTH-1]) & (|right);
      negRem_d = left[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
    end else begin
      negQuo_q <= negQuo_d;
      negRem_q <= negRem_d;
    end
  end
`else
  assign leftMag  = left;
  assign rightMag = right;
  assign quoFixed = quoFinal;
  assign remFixed = remFinal;
`endif

  // Next-state and datapath control. Results are written only on the last
  // iteration, so outputs stay stable through IDLE and the following BUSY.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dq_d      = dq_q;
    divisor_d = divisor_q;
    partRem_d = partRem_q;
    resQuo_d  = resQuo_q;
    resRem_d  = resRem_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d   = BUSY;
          dq_d      = leftMag;
          divisor_d = rightMag;
          partRem_d = '0;
          count_d   = CW'(WIDTH);
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        partRem_d = stepRem;
        dq_d      = quoFinal;
        count_d   = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d  = DONE;
          resQuo_d = quoFixed;
          resRem_d = remFixed;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      dq_q      <= '0;
      divisor_q <= '0;
      partRem_q <= '0;
      resQuo_q  <= '0;
      resRem_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dq_q      <= dq_d;
      divisor_q <= divisor_d;
      partRem_q <= partRem_d;
      resQuo_q  <= resQuo_d;
      resRem_q  <= resRem_d;
      done_q    <= done_d;
    end
  end

  assign out_quotient  = resQuo_q;
  assign out_remainder = resRem_q;
  assign done          = done_q;

endmodule

// File: tb/tb_std_seq_divmod.sv
// tb_std_seq_divmod
// Self-checking bench for std_seq_divmod at WIDTH=32. Follows
// STD_SEQ_DIVMOD_SIGNED_EN so the same bench covers both builds.
`timescale 1ns/1ps
module tb_std_seq_divmod;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } res_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         go = 1'b0;
  logic [W-1:0] left = '0;
  logic [W-1:0] right = '0;
  logic [W-1:0] outQuotient;
  logic [W-1:0] outRemainder;
  logic         done;

  int   checks = 0;
  int   failures = 0;
  res_t expQ[$];
  logic prevDone = 1'b0;
  vec_t tab[8];

  std_seq_divmod #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .left          (left),
    .right         (right),
    .out_quotient  (outQuotient),
    .out_remainder (outRemainder),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference result built from the language operators.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    if (b == '0) begin
      r.q = '1;
      r.r = a;
    end
`ifdef STD_SEQ_DIVMOD_SIGNED_EN
    else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      r.q = a;
      r.r = '0;
    end else begin
      r.q = $signed(a) / $signed(b);
      r.r = $signed(a) % $signed(b);
    end
`else
    else begin
      r.q = a / b;
      r.r = a % b;
    end
`endif
    return r;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    res_t e;
    if (done === 1'b1) begin
      checkOutput("done_not_repeated", {31'b0, prevDone}, '0);
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL spurious_done: done=1 with no pending result, required done=0");
      end else begin
        e = expQ.pop_front();
        checkOutput("quotient", outQuotient, e.q);
        checkOutput("remainder", outRemainder, e.r);
      end
    end
    prevDone = done;
  end

  // Caller sits on a negedge; go is held for exactly one rising edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input res_t e);
    left  = a;
    right = b;
    go    = 1'b1;
    expQ.push_back(e);
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input res_t e);
    int cyc;
    applyStimulus(a, b, e);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("latency", cyc, LAT);
    @(negedge clk);
  endtask

  initial begin
    int   cyc;
    int   extraDones;
    res_t e;
    logic [W-1:0] a, b;

`ifdef STD_SEQ_DIVMOD_SIGNED_EN
    tab[0] = '{32'd100,        32'd7,          32'd14,         32'd2};
    tab[1] = '{32'hDEADBEEF,   32'd0,          32'hFFFFFFFF,   32'hDEADBEEF};
    tab[2] = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
    tab[3] = '{32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
    tab[4] = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
    tab[5] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
    tab[6] = '{32'd0,          32'hFFFFFFFB,   32'd0,          32'd0};
    tab[7] = '{32'h12345678,   32'd10,         32'h01D208A5,   32'd6};
`else
    tab[0] = '{32'd100,        32'd7,          32'd14,         32'd2};
    tab[1] = '{32'hDEADBEEF,   32'd0,          32'hFFFFFFFF,   32'hDEADBEEF};
    tab[2] = '{32'd0,          32'd5,          32'd0,          32'd0};
    tab[3] = '{32'd5,          32'd10,         32'd0,          32'd5};
    tab[4] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
    tab[5] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0};
    tab[6] = '{32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
    tab[7] = '{32'h12345678,   32'd10,         32'h01D208A5,   32'd6};
`endif

    // Reset state
    #2 reset = 1'b0;
    #2;
    checkOutput("reset_quotient", outQuotient, '0);
    checkOutput("reset_remainder", outRemainder, '0);
    checkOutput("reset_done", {31'b0, done}, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven vectors, with a hold check after the first one
    for (int i = 0; i < 8; i++) begin
      e.q = tab[i].q;
      e.r = tab[i].r;
      runOp(tab[i].a, tab[i].b, e);
      if (i == 0) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          checkOutput("hold_quotient", outQuotient, tab[0].q);
          checkOutput("hold_remainder", outRemainder, tab[0].r);
          checkOutput("hold_done", {31'b0, done}, '0);
        end
      end
    end

    // Back-to-back with go held high; operand changes mid-BUSY must be ignored
    left  = 32'd50;
    right = 32'd5;
    go    = 1'b1;
    e.q = 32'd10; e.r = 32'd0;
    expQ.push_back(e);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        left  = 32'd999;
        right = 32'd3;
      end
    end
    checkOutput("b2b_first_latency", cyc, LAT);
    left  = 32'd9;
    right = 32'd4;
    e.q = 32'd2; e.r = 32'd1;
    expQ.push_back(e);
    @(negedge clk);
    go = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("b2b_gap", cyc, LAT);
    extraDones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) extraDones++;
    end
    checkOutput("b2b_no_third_done", extraDones, 0);

    // Reset in the middle of an operation: nothing is queued for it
    left  = 32'd123456;
    right = 32'd789;
    go    = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset_quotient", outQuotient, '0);
    checkOutput("midreset_remainder", outRemainder, '0);
    checkOutput("midreset_done", {31'b0, done}, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    e.q = 32'd2; e.r = 32'd1;
    runOp(32'd7, 32'd3, e);

    // Random operands, including zero and small divisors
    for (int n = 0; n < 200; n++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = $urandom_range(1, 255);
        3:       b = -$urandom_range(1, 255);
        default: b = $urandom;
      endcase
      runOp(a, b, model(a, b));
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
